slc_datapath_gen: RTL and testbench
===================================

// Module: slc_datapath_gen
// PURPOSE
//   Parametrised next-generation SLC-3 datapath: PC/MAR/MDR/IR, register file, ALU, address adder, CC and BEN.
//   Adds a memory request/acknowledge FSM with timeout, replacing fixed memory wait states.
//   Adds explicit bus-contention detection. Sits between the ISDU control FSM and the memory/IO bridge.
// PARAMETERS
//   DATA_W      16       datapath width, >=16; IR decode uses IR[15:0], immediates sign-extended to DATA_W
//   NREG        8        register-file depth, power of 2, >=8; only R0..R7 are addressable
//   RESET_PC    'h0000   PC value loaded on Reset
//   TIMEOUT_CYC 255      max wait cycles for MEM_ACK before abort, 1..2^16-1
// PORTS
//   Clk          in   1       clock, rising edge
//   Reset        in   1       synchronous, active-high
//   LD_MAR/LD_MDR/LD_IR/LD_BEN/LD_CC/LD_REG/LD_PC  in 1 each   register load enables
//   GatePC/GateMDR/GateALU/GateMARMUX              in 1 each   bus drive selects
//   SR1MUX/SR2MUX/DRMUX/ADDR1MUX                   in 1 each   mux selects
//   PCMUX/ADDR2MUX/ALUK                            in 2 each   mux/op selects
//   MEM_RD/MEM_WR in 1 each   start read/write of M[MAR]; sampled in IDLE only
//   MEM_ACK      in   1       memory completes current transaction
//   MEM_DATA_IN  in   DATA_W  read data, valid when MEM_ACK=1
//   MEM_REQ/MEM_WE out 1 each transaction active / write strobe
//   MEM_ADDR/MEM_DATA_OUT out DATA_W  = MAR / = MDR
//   MEM_BUSY     out  1       FSM not IDLE
//   MEM_TIMEOUT  out  1       sticky: a transaction was aborted
//   BUS_ERR      out  1       combinational: >1 gate asserted
//   PC/MAR/MDR/IR/BUS out DATA_W   BEN out 1
// BEHAVIOUR
//   Reset: PC=RESET_PC; MAR=MDR=IR=all regs=0; CC=Z (3'b010); BEN=0; FSM=IDLE; MEM_TIMEOUT=0; MEM_REQ=MEM_WE=0.
//   All registers update on rising Clk; Reset overrides every load, including mid-transaction (MEM_REQ low after edge).
//   BUS: one-hot gate -> PC/MDR/ALU/addr-adder; no gate -> 0; >1 gate -> BUS=0, BUS_ERR=1 (same cycle).
//   ALUK: 00 A+B (mod 2^DATA_W), 01 A&B, 10 ~A, 11 A. A=SR1; B=SR2MUX ? sext(IR[4:0]) : R[IR[2:0]].
//   SR1 = SR1MUX ? IR[8:6] : IR[11:9]; DR = DRMUX ? R7 : IR[11:9]; LD_REG writes BUS to DR.
//   Address adder = ADDR1 + ADDR2; ADDR1MUX 0 PC, 1 SR1; ADDR2MUX 00 0, 01 sext IR[5:0], 10 sext IR[8:0], 11 sext IR[10:0].
//   PCMUX: 00 PC+1 (wraps all-ones->0), 01 BUS, 10 address adder, 11 PC (hold).
//   LD_CC: CC <= BUS[DATA_W-1] ? N(100) : BUS==0 ? Z(010) : P(001).
//   LD_BEN: BEN <= |(IR[11:9] & CC); uses CC before any same-edge CC update.
//   LD_IR loads BUS. LD_MAR loads BUS only in IDLE; ignored while MEM_BUSY.
//   Memory FSM states IDLE, RD_WAIT, WR_WAIT; wait counter cleared on IDLE exit.
//     IDLE: MEM_RD=1 -> RD_WAIT; else MEM_WR=1 -> WR_WAIT; both high -> read wins, write dropped.
//     RD_WAIT: MEM_REQ=1, MEM_WE=0; MEM_ACK -> MDR<=MEM_DATA_IN, IDLE.
//     WR_WAIT: MEM_REQ=1, MEM_WE=1; MEM_ACK -> IDLE.
//     Either wait state: counter reaches TIMEOUT_CYC with no ACK -> IDLE, MEM_TIMEOUT<=1, MDR unchanged.
//     ACK in the timeout cycle counts as success.
//   Minimum transaction: request edge, ACK in 1st wait cycle -> 2 cycles; MEM_BUSY high in wait states only.
//   MEM_RD/MEM_WR while busy are ignored (not queued). MEM_ACK in IDLE is ignored.
//   MDR loading: LD_MDR loads BUS in IDLE; in RD_WAIT, ACK load beats LD_MDR; in WR_WAIT, LD_MDR ignored.
// TESTING
//   Reset, RESET_PC='h3000 -> PC=3000, CC=010, BEN=0, MEM_REQ=0 on the next cycle.
//   R1=5, R2=-7 (FFF9), ADD R3,R1,R2 with LD_CC -> R3=FFFE, CC=100; BRn sets BEN=1; BRzp sets BEN=0.
//   MAR=1234, MEM_RD, ACK after 3 cycles, data BEEF -> MDR=BEEF; MEM_BUSY high exactly 3 cycles.
//   TIMEOUT_CYC=4, MEM_WR, no ACK -> MEM_REQ drops after 4 wait cycles; MEM_TIMEOUT=1 until Reset.
//   GatePC+GateALU together -> BUS=0, BUS_ERR=1; LD_MAR during RD_WAIT -> MAR unchanged.
//   Reset in RD_WAIT with ACK same edge -> IDLE, MDR=0; PC=FFFF, PCMUX=00, LD_PC -> PC=0000.

Source files
------------

// File: rtl/slc_datapath_gen.sv
// SLC-3 datapath: PC/MAR/MDR/IR, register file, ALU, address adder, CC/BEN,
// plus a request/acknowledge memory FSM with timeout and bus-contention flag.

module slc_datapath_alu #(
    parameter int DATA_W = 16
) (
    input  logic [1:0]        aluk,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);
    always_comb begin
        y = a;
        case (aluk)
            2'b00:   y = a + b;
            2'b01:   y = a & b;
            2'b10:   y = ~a;
            default: y = a;
        endcase
    end
endmodule

module slc_datapath_addr #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] ir,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] sr1,
    input  logic              addr1mux,
    input  logic [1:0]        addr2mux,
    output logic [DATA_W-1:0] sum
);
    logic [DATA_W-1:0] addr1;
    logic [DATA_W-1:0] addr2;
    logic [DATA_W-1:0] off6;
    logic [DATA_W-1:0] off9;
    logic [DATA_W-1:0] off11;
    logic              ir_unused;

    assign off6      = {{(DATA_W-6){ir[5]}}, ir[5:0]};
    assign off9      = {{(DATA_W-9){ir[8]}}, ir[8:0]};
    assign off11     = {{(DATA_W-11){ir[10]}}, ir[10:0]};
    assign ir_unused = ^ir[DATA_W-1:11];
    assign addr1     = addr1mux ? sr1 : pc;

    always_comb begin
        addr2 = '0;
        case (addr2mux)
            2'b00:   addr2 = '0;
            2'b01:   addr2 = off6;
            2'b10:   addr2 = off9;
            default: addr2 = off11;
        endcase
    end

    assign sum = addr1 + addr2;
endmodule

module slc_datapath_gen #(
    parameter int                DATA_W      = 16,
    parameter int                NREG        = 8,
    parameter logic [DATA_W-1:0] RESET_PC    = 'h0000,
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              LD_IR,
    input  logic              LD_BEN,
    input  logic              LD_CC,
    input  logic              LD_REG,
    input  logic              LD_PC,
    input  logic              GatePC,
    input  logic              GateMDR,
    input  logic              GateALU,
    input  logic              GateMARMUX,
    input  logic              SR1MUX,
    input  logic              SR2MUX,
    input  logic              DRMUX,
    input  logic              ADDR1MUX,
    input  logic [1:0]        PCMUX,
    input  logic [1:0]        ADDR2MUX,
    input  logic [1:0]        ALUK,
    input  logic              MEM_RD,
    input  logic              MEM_WR,
    input  logic              MEM_ACK,
    input  logic [DATA_W-1:0] MEM_DATA_IN,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [DATA_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DATA_OUT,
    output logic              MEM_BUSY,
    output logic              MEM_TIMEOUT,
    output logic              BUS_ERR,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] MAR,
    output logic [DATA_W-1:0] MDR,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] BUS,
    output logic              BEN
);
    localparam int RIDX_W = $clog2(NREG);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    logic [1:0]        state;
    logic [15:0]       wait_cnt;
    logic [2:0]        cc;
    logic [DATA_W-1:0] regs [NREG];

    logic [2:0]        sr1_idx;
    logic [2:0]        dr_idx;
    logic [DATA_W-1:0] sr1_val;
    logic [DATA_W-1:0] sr2_val;
    logic [DATA_W-1:0] imm5;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] addr_sum;
    logic [3:0]        gates;
    logic              idle;
    logic              wait_done;
    logic              timed_out;
    logic              ir_unused;

    assign ir_unused = ^IR[DATA_W-1:12];

    // Only R0..R7 are reachable; deeper entries exist but are never addressed.
    assign sr1_idx = SR1MUX ? IR[8:6] : IR[11:9];
    assign dr_idx  = DRMUX ? 3'd7 : IR[11:9];
    assign sr1_val = regs[RIDX_W'(sr1_idx)];
    assign sr2_val = regs[RIDX_W'(IR[2:0])];
    assign imm5    = {{(DATA_W-5){IR[4]}}, IR[4:0]};
    assign alu_b   = SR2MUX ? imm5 : sr2_val;

    slc_datapath_alu #(.DATA_W(DATA_W)) u_alu (
        .aluk (ALUK),
        .a    (sr1_val),
        .b    (alu_b),
        .y    (alu_out)
    );

    slc_datapath_addr #(.DATA_W(DATA_W)) u_addr (
        .ir       (IR),
        .pc       (PC),
        .sr1      (sr1_val),
        .addr1mux (ADDR1MUX),
        .addr2mux (ADDR2MUX),
        .sum      (addr_sum)
    );

    // Contention forces the bus to zero rather than picking a winner.
    assign gates   = {GatePC, GateMDR, GateALU, GateMARMUX};
    assign BUS_ERR = (gates & (gates - 4'd1)) != 4'd0;

    always_comb begin
        BUS = '0;
        case (gates)
            4'b1000: BUS = PC;
            4'b0100: BUS = MDR;
            4'b0010: BUS = alu_out;
            4'b0001: BUS = addr_sum;
            default: BUS = '0;
        endcase
    end

    assign idle         = (state == S_IDLE);
    assign MEM_BUSY     = !idle;
    assign MEM_REQ      = !idle;
    assign MEM_WE       = (state == S_WR);
    assign MEM_ADDR     = MAR;
    assign MEM_DATA_OUT = MDR;
    assign wait_done    = !idle && MEM_ACK;
    assign timed_out    = !idle && !MEM_ACK && (wait_cnt == WAIT_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            MEM_TIMEOUT <= 1'b0;
        end else if (idle) begin
            wait_cnt <= '0;
            if (MEM_RD)
                state <= S_RD;
            else if (MEM_WR)
                state <= S_WR;
        end else if (wait_done) begin
            state <= S_IDLE;
        end else if (timed_out) begin
            state       <= S_IDLE;
            MEM_TIMEOUT <= 1'b1;
        end else begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            PC  <= RESET_PC;
            MAR <= '0;
            MDR <= '0;
            IR  <= '0;
            cc  <= 3'b010;
            BEN <= 1'b0;
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            if (LD_MAR && idle)
                MAR <= BUS;
            // Read data wins over LD_MDR; a pending write holds MDR steady.
            if (state == S_RD && MEM_ACK)
                MDR <= MEM_DATA_IN;
            else if (LD_MDR && state != S_WR)
                MDR <= BUS;
            if (LD_IR)
                IR <= BUS;
            if (LD_BEN)
                BEN <= |(IR[11:9] & cc);
            if (LD_CC)
                cc <= BUS[DATA_W-1] ? 3'b100 : (BUS == '0) ? 3'b010 : 3'b001;
            if (LD_REG)
                regs[RIDX_W'(dr_idx)] <= BUS;
            if (LD_PC) begin
                case (PCMUX)
                    2'b00:   PC <= PC + 1'b1;
                    2'b01:   PC <= BUS;
                    2'b10:   PC <= addr_sum;
                    default: PC <= PC;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_slc_datapath_gen.sv
// Directed bench for slc_datapath_gen: vector table for datapath ops,
// hand sequences for memory handshake, timeout, contention and reset cases.

module tb_slc_datapath_gen;
    logic        Clk;
    logic        Reset;
    logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic        SR1MUX, SR2MUX, DRMUX, ADDR1MUX;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        MEM_RD, MEM_WR, MEM_ACK;
    logic [15:0] MEM_DATA_IN;
    logic        MEM_REQ, MEM_WE, MEM_BUSY, MEM_TIMEOUT, BUS_ERR, BEN;
    logic [15:0] MEM_ADDR, MEM_DATA_OUT, PC, MAR, MDR, IR, BUS;

    int n_cmp = 0;
    int n_bad = 0;

    slc_datapath_gen #(
        .DATA_W(16), .NREG(8), .RESET_PC(16'h3000), .TIMEOUT_CYC(4)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .DRMUX(DRMUX), .ADDR1MUX(ADDR1MUX),
        .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .MEM_ACK(MEM_ACK), .MEM_DATA_IN(MEM_DATA_IN),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DATA_OUT(MEM_DATA_OUT),
        .MEM_BUSY(MEM_BUSY), .MEM_TIMEOUT(MEM_TIMEOUT), .BUS_ERR(BUS_ERR),
        .PC(PC), .MAR(MAR), .MDR(MDR), .IR(IR), .BUS(BUS), .BEN(BEN)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // gate = {PC,MDR,ALU,MARMUX}; ld = {MAR,MDR,IR,BEN,CC,REG,PC}; mux = {SR1,SR2,DR,ADDR1}
    typedef struct {
        logic [15:0] ir;
        logic [3:0]  gate;
        logic [6:0]  ld;
        logic [3:0]  mux;
        logic [1:0]  pcmux;
        logic [1:0]  addr2mux;
        logic [1:0]  aluk;
        logic [15:0] exp_bus;
        logic        exp_ben;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(logic [15:0] ir, logic [3:0] gate, logic [6:0] ld,
                                logic [3:0] mux, logic [1:0] pcm, logic [1:0] a2m,
                                logic [1:0] alk, logic [15:0] bus, logic ben,
                                logic [15:0] pc);
        vec_t v;
        v.ir = ir; v.gate = gate; v.ld = ld; v.mux = mux; v.pcmux = pcm;
        v.addr2mux = a2m; v.aluk = alk; v.exp_bus = bus; v.exp_ben = ben; v.exp_pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC} = '0;
        {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
        {SR1MUX, SR2MUX, DRMUX, ADDR1MUX} = '0;
        PCMUX = 2'b00; ADDR2MUX = 2'b00; ALUK = 2'b00;
        MEM_RD = 1'b0; MEM_WR = 1'b0; MEM_ACK = 1'b0; MEM_DATA_IN = '0;
    endtask

    // Fetch through the memory port: one request cycle, ACK in the first wait cycle.
    task automatic load_ir(input logic [15:0] val);
        clr();
        MEM_RD = 1'b1;
        tick();
        MEM_RD = 1'b0;
        MEM_ACK = 1'b1;
        MEM_DATA_IN = val;
        tick();
        clr();
        chk("min_txn_idle", {15'd0, MEM_BUSY}, 16'd0);
        GateMDR = 1'b1;
        LD_IR = 1'b1;
        tick();
        clr();
    endtask

    task automatic apply(input vec_t v, input int idx);
        load_ir(v.ir);
        {GatePC, GateMDR, GateALU, GateMARMUX} = v.gate;
        {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC} = v.ld;
        {SR1MUX, SR2MUX, DRMUX, ADDR1MUX} = v.mux;
        PCMUX = v.pcmux; ADDR2MUX = v.addr2mux; ALUK = v.aluk;
        #2;
        chk($sformatf("vec%0d_bus", idx), BUS, v.exp_bus);
        tick();
        clr();
        chk($sformatf("vec%0d_ben", idx), {15'd0, BEN}, {15'd0, v.exp_ben});
        chk($sformatf("vec%0d_pc", idx), PC, v.exp_pc);
    endtask

    initial begin
        int busy_cnt;
        int req_cnt;
        logic we_all;

        vecs[0]  = mk(16'h1225, 4'h2, 7'h02, 4'hC, 2'd0, 2'd0, 2'd0, 16'h0005, 1'b1, 16'h3000);
        vecs[1]  = mk(16'h1439, 4'h2, 7'h02, 4'hC, 2'd0, 2'd0, 2'd0, 16'hFFF9, 1'b1, 16'h3000);
        vecs[2]  = mk(16'h1642, 4'h2, 7'h06, 4'h8, 2'd0, 2'd0, 2'd0, 16'hFFFE, 1'b1, 16'h3000);
        vecs[3]  = mk(16'h0800, 4'h0, 7'h08, 4'h0, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b1, 16'h3000);
        vecs[4]  = mk(16'h0600, 4'h0, 7'h08, 4'h0, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b0, 16'h3000);
        vecs[5]  = mk(16'h0600, 4'h2, 7'h00, 4'h0, 2'd0, 2'd0, 2'd3, 16'hFFFE, 1'b0, 16'h3000);
        vecs[6]  = mk(16'h58EF, 4'h2, 7'h06, 4'hC, 2'd0, 2'd0, 2'd1, 16'h000E, 1'b0, 16'h3000);
        vecs[7]  = mk(16'h9AFF, 4'h2, 7'h02, 4'h8, 2'd0, 2'd0, 2'd2, 16'h0001, 1'b0, 16'h3000);
        vecs[8]  = mk(16'h0200, 4'h0, 7'h08, 4'h0, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b1, 16'h3000);
        vecs[9]  = mk(16'h01FF, 4'h1, 7'h01, 4'h0, 2'd2, 2'd2, 2'd0, 16'h2FFF, 1'b1, 16'h2FFF);
        vecs[10] = mk(16'h0401, 4'h1, 7'h00, 4'h0, 2'd0, 2'd3, 2'd0, 16'h2C00, 1'b1, 16'h2FFF);
        vecs[11] = mk(16'h0160, 4'h1, 7'h00, 4'h9, 2'd0, 2'd1, 2'd0, 16'hFFE1, 1'b1, 16'h2FFF);
        vecs[12] = mk(16'h0160, 4'h1, 7'h01, 4'h9, 2'd1, 2'd0, 2'd0, 16'h0001, 1'b1, 16'h0001);
        vecs[13] = mk(16'h0160, 4'h8, 7'h01, 4'h0, 2'd0, 2'd0, 2'd0, 16'h0001, 1'b1, 16'h0002);
        vecs[14] = mk(16'h0160, 4'h8, 7'h01, 4'h0, 2'd3, 2'd0, 2'd0, 16'h0002, 1'b1, 16'h0002);
        vecs[15] = mk(16'h0160, 4'h8, 7'h02, 4'h2, 2'd0, 2'd0, 2'd0, 16'h0002, 1'b1, 16'h0002);
        vecs[16] = mk(16'h0E00, 4'h2, 7'h00, 4'h0, 2'd0, 2'd0, 2'd3, 16'h0002, 1'b1, 16'h0002);
        vecs[17] = mk(16'h0400, 4'h0, 7'h0C, 4'h0, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b0, 16'h0002);
        vecs[18] = mk(16'h0400, 4'h0, 7'h08, 4'h0, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b1, 16'h0002);

        // Reset state
        clr();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        chk("rst_pc", PC, 16'h3000);
        chk("rst_mar", MAR, 16'h0000);
        chk("rst_mdr", MDR, 16'h0000);
        chk("rst_ir", IR, 16'h0000);
        chk("rst_ben", {15'd0, BEN}, 16'd0);
        chk("rst_req", {15'd0, MEM_REQ}, 16'd0);
        chk("rst_busy", {15'd0, MEM_BUSY}, 16'd0);
        chk("rst_timeout", {15'd0, MEM_TIMEOUT}, 16'd0);

        // CC resets to Z: BRz must set BEN
        load_ir(16'h0400);
        LD_BEN = 1'b1;
        tick();
        clr();
        chk("rst_cc_z", {15'd0, BEN}, 16'd1);

        for (int i = 0; i < 19; i++)
            apply(vecs[i], i);

        // Bus contention
        clr();
        GatePC = 1'b1;
        GateALU = 1'b1;
        #1;
        chk("contend_bus", BUS, 16'h0000);
        chk("contend_err", {15'd0, BUS_ERR}, 16'd1);
        GateALU = 1'b0;
        #1;
        chk("single_err", {15'd0, BUS_ERR}, 16'd0);
        chk("single_bus", BUS, 16'h0002);
        tick();
        clr();

        // Read with ACK in third wait cycle; RD and WR together -> read
        load_ir(16'h1234);
        GateMDR = 1'b1;
        LD_MAR = 1'b1;
        tick();
        clr();
        chk("mar_load", MAR, 16'h1234);
        MEM_RD = 1'b1;
        MEM_WR = 1'b1;
        tick();
        clr();
        busy_cnt = 0;
        for (int c = 1; c <= 3; c++) begin
            if (MEM_BUSY) busy_cnt++;
            if (c == 1) begin
                chk("rd_we_low", {15'd0, MEM_WE}, 16'd0);
                chk("rd_addr", MEM_ADDR, 16'h1234);
                GatePC = 1'b1;
                LD_MAR = 1'b1;
            end else begin
                GatePC = 1'b0;
                LD_MAR = 1'b0;
            end
            if (c == 3) begin
                MEM_ACK = 1'b1;
                MEM_DATA_IN = 16'hBEEF;
            end
            tick();
        end
        clr();
        chk("rd_busy_cycles", 16'(busy_cnt), 16'd3);
        chk("rd_done_idle", {15'd0, MEM_BUSY}, 16'd0);
        chk("rd_mdr", MDR, 16'hBEEF);
        chk("rd_data_out", MEM_DATA_OUT, 16'hBEEF);
        chk("mar_held_busy", MAR, 16'h1234);
        tick();
        chk("wr_dropped", {15'd0, MEM_BUSY}, 16'd0);
        chk("pre_timeout", {15'd0, MEM_TIMEOUT}, 16'd0);

        // Write that never gets ACK
        MEM_WR = 1'b1;
        tick();
        clr();
        req_cnt = 0;
        we_all = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!MEM_REQ) break;
            if (!MEM_WE) we_all = 1'b0;
            GatePC = (i == 0);
            LD_MDR = (i == 0);
            req_cnt++;
            tick();
        end
        clr();
        chk("to_req_cycles", 16'(req_cnt), 16'd4);
        chk("to_we", {15'd0, we_all}, 16'd1);
        chk("to_flag", {15'd0, MEM_TIMEOUT}, 16'd1);
        chk("to_mdr_kept", MDR, 16'hBEEF);
        tick();
        tick();
        chk("to_sticky", {15'd0, MEM_TIMEOUT}, 16'd1);

        // Reset in RD_WAIT with ACK on the same edge
        MEM_RD = 1'b1;
        tick();
        clr();
        chk("rst_rd_busy", {15'd0, MEM_BUSY}, 16'd1);
        Reset = 1'b1;
        MEM_ACK = 1'b1;
        MEM_DATA_IN = 16'h1111;
        tick();
        Reset = 1'b0;
        clr();
        chk("rst_rd_req", {15'd0, MEM_REQ}, 16'd0);
        chk("rst_rd_mdr", MDR, 16'h0000);
        chk("rst_rd_timeout", {15'd0, MEM_TIMEOUT}, 16'd0);
        chk("rst_rd_pc", PC, 16'h3000);

        // PC wrap: ~R0 -> PC=FFFF, then PC+1 -> 0
        GateALU = 1'b1;
        ALUK = 2'b10;
        PCMUX = 2'b01;
        LD_PC = 1'b1;
        tick();
        clr();
        chk("pc_ffff", PC, 16'hFFFF);
        PCMUX = 2'b00;
        LD_PC = 1'b1;
        tick();
        clr();
        chk("pc_wrap", PC, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
